// File: rtl/ps2_scan_ctl_if.sv
// Signal bundle between the PS/2 byte receiver / host side and the scan-code controller.
// The controller attaches through the slave modport; the environment drives through master.
interface ps2_scan_ctl_if;
    logic [7:0] rx_code;
    logic       rx_parity;
    logic       rx_rdy;
    logic       rx_error;
    logic       rx_busy;
    logic       rx_reset;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_rel;
    logic       key_ack;
    logic       overflow;
    logic       ovf_clr;
    logic [7:0] perr_cnt;
    logic       idle;

    modport master (
        output rx_code, rx_parity, rx_rdy, rx_error, rx_busy, key_ack, ovf_clr,
        input  rx_reset, key_valid, key_code, key_ext, key_rel, overflow, perr_cnt, idle
    );

    modport slave (
        input  rx_code, rx_parity, rx_rdy, rx_error, rx_busy, key_ack, ovf_clr,
        output rx_reset, key_valid, key_code, key_ext, key_rel, overflow, perr_cnt, idle
    );
endinterface

// File: rtl/ps2_scan_ctl.sv
// PS/2 set-2 scan-code controller: parity check, E0/F0 prefix decode, show-ahead event
// FIFO for the host, and a timed receiver-reset sequence after framing or parity errors.
module ps2_scan_ctl #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int RST_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    ps2_scan_ctl_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_EXT, S_REL, S_EXTREL, S_RECOVER} state_e;

    localparam logic [7:0] RCNT_LAST = 8'(RST_CYCLES - 1);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [7:0]    rcnt_q, rcnt_d;
    logic          parity_ok;
    logic          push;
    logic          perr_inc;
    logic [9:0]    push_entry;

    // Event entry layout: {ext, rel, code}
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [9:0]    head_q, head_d;
    logic          full, pop, accept;
    logic          ovf_q;
    logic          rx_reset_q;
    logic [7:0]    perr_q;

    assign parity_ok = ^{bus.rx_code, bus.rx_parity};

    always_comb begin
        state_d    = state_q;
        rcnt_d     = '0;
        push       = 1'b0;
        perr_inc   = 1'b0;
        push_entry = {(state_q == S_EXT) || (state_q == S_EXTREL),
                      (state_q == S_REL) || (state_q == S_EXTREL),
                      bus.rx_code};
        case (state_q)
            S_RECOVER: begin
                rcnt_d = rcnt_q + 8'd1;
                if (rcnt_q == RCNT_LAST) state_d = S_IDLE;
            end
            default: begin
                if (bus.rx_error) begin
                    state_d = S_RECOVER;
                end else if (bus.rx_rdy) begin
                    if (!parity_ok) begin
                        perr_inc = 1'b1;
                        state_d  = S_RECOVER;
                    end else if (bus.rx_code == 8'hE0) begin
                        // A repeated or late E0 never clears a pending release prefix
                        if (state_q == S_IDLE) state_d = S_EXT;
                    end else if (bus.rx_code == 8'hF0) begin
                        if (state_q == S_IDLE)     state_d = S_REL;
                        else if (state_q == S_EXT) state_d = S_EXTREL;
                    end else begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    assign full   = (count_q == DEPTH_C);
    assign pop    = bus.key_ack && (count_q != '0);
    assign accept = push && (!full || pop);

    // Head register tracks the next entry so the outputs hold their last value once empty
    always_comb begin
        head_d = head_q;
        if (pop && (count_q > CNT_ONE))
            head_d = mem[rd_ptr_q + AW'(1)];
        else if (accept && ((count_q == '0) || pop))
            head_d = push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            ovf_q      <= 1'b0;
            rx_reset_q <= 1'b0;
            perr_q     <= '0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            rx_reset_q <= (state_d == S_RECOVER);
            head_q     <= head_d;
            count_q    <= count_q + (AW+1)'(accept) - (AW+1)'(pop);
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && full && !pop) ovf_q <= 1'b1;
            else if (bus.ovf_clr)     ovf_q <= 1'b0;
            if (perr_inc && (perr_q != 8'hFF)) perr_q <= perr_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= push_entry;
    end

    assign bus.rx_reset  = rx_reset_q;
    assign bus.key_valid = (count_q != '0);
    assign bus.key_ext   = head_q[9];
    assign bus.key_rel   = head_q[8];
    assign bus.key_code  = head_q[7:0];
    assign bus.overflow  = ovf_q;
    assign bus.perr_cnt  = perr_q;
    assign bus.idle      = (state_q == S_IDLE) && !bus.rx_busy;
endmodule

// File: tb/tb_ps2_scan_ctl.sv
// Self-checking bench for ps2_scan_ctl: directed vector table, hand-written corner
// sequences and randomized traffic, all tracked by an event-queue reference model.
module tb_ps2_scan_ctl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int RST   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_scan_ctl_if bus();

    ps2_scan_ctl #(.DEPTH(DEPTH), .AW(AW), .RST_CYCLES(RST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: prefix flags, recovery countdown, event queue of {ext, rel, code}
    logic [9:0] mq[$];
    bit         m_ext, m_rel, m_ovf;
    int         m_rec, m_perr;
    logic [9:0] m_head;

    typedef struct {
        logic [7:0] code;
        logic       par;
        logic       rdy;
        logic       ack;
        logic       exp_valid;
        logic [7:0] exp_code;
        logic       exp_ext;
        logic       exp_rel;
    } vec_t;

    vec_t vt[13];

    function automatic logic par_of(input logic [7:0] c);
        return ~(^c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ext = 0; m_rel = 0; m_ovf = 0;
        m_rec = 0; m_perr = 0;
        m_head = '0;
    endtask

    task automatic model_step();
        bit         pop, push, set_ovf;
        int         sz;
        logic [9:0] ev;
        pop = bus.key_ack && (mq.size() > 0);
        sz = mq.size();
        push = 0; set_ovf = 0; ev = '0;
        if (m_rec > 0) begin
            m_rec--;
        end else if (bus.rx_error) begin
            m_ext = 0; m_rel = 0; m_rec = RST;
        end else if (bus.rx_rdy) begin
            if ((^{bus.rx_code, bus.rx_parity}) == 1'b0) begin
                if (m_perr < 255) m_perr++;
                m_ext = 0; m_rel = 0; m_rec = RST;
            end else if (bus.rx_code == 8'hE0) begin
                if (!m_rel) m_ext = 1;
            end else if (bus.rx_code == 8'hF0) begin
                m_rel = 1;
            end else begin
                ev = {m_ext, m_rel, bus.rx_code};
                push = 1;
                m_ext = 0; m_rel = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (sz < DEPTH || pop) mq.push_back(ev);
            else set_ovf = 1;
        end
        if (set_ovf) m_ovf = 1;
        else if (bus.ovf_clr) m_ovf = 0;
        if (mq.size() > 0) m_head = mq[0];
    endtask

    task automatic compare_all();
        chk("m_valid", bus.key_valid, mq.size() > 0);
        chk("m_code",  bus.key_code,  m_head[7:0]);
        chk("m_ext",   bus.key_ext,   m_head[9]);
        chk("m_rel",   bus.key_rel,   m_head[8]);
        chk("m_ovf",   bus.overflow,  m_ovf);
        chk("m_perr",  bus.perr_cnt,  m_perr);
        chk("m_rxrst", bus.rx_reset,  m_rec > 0);
        chk("m_idle",  bus.idle,      (m_rec == 0) && !m_ext && !m_rel && !bus.rx_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        bus.rx_rdy  = 1'b0;
        bus.key_ack = 1'b0;
        bus.ovf_clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input logic p, input logic a);
        bus.rx_code   = c;
        bus.rx_parity = p;
        bus.rx_rdy    = 1'b1;
        bus.key_ack   = a;
        tick();
    endtask

    // Counts cycles with rx_reset high; optionally offers good bytes that must be ignored
    task automatic wait_recover(input string name, input bit inject);
        int n = 0;
        while (bus.rx_reset && n < 200) begin
            n++;
            if (inject) begin
                bus.rx_code = 8'h22; bus.rx_parity = par_of(8'h22); bus.rx_rdy = 1'b1;
            end
            tick();
        end
        chk(name, n, RST);
    endtask

    initial begin
        logic [7:0] exp_pop[$];
        rst = 1'b1;
        bus.rx_code = '0; bus.rx_parity = 0; bus.rx_rdy = 0; bus.rx_error = 0;
        bus.rx_busy = 0; bus.key_ack = 0; bus.ovf_clr = 0;
        model_reset();
        #12;
        chk("rst_valid", bus.key_valid, 0);
        chk("rst_code",  bus.key_code,  0);
        chk("rst_ext",   bus.key_ext,   0);
        chk("rst_rel",   bus.key_rel,   0);
        chk("rst_ovf",   bus.overflow,  0);
        chk("rst_perr",  bus.perr_cnt,  0);
        chk("rst_rxrst", bus.rx_reset,  0);
        chk("rst_idle",  bus.idle,      1);
        rst = 1'b0;

        // code, parity, rdy, ack -> valid, code, ext, rel
        vt[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0};
        vt[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b0};
        vt[2]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0};
        vt[3]  = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b0, 1'b0};
        vt[4]  = '{8'h75, 1'b0, 1'b1, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1};
        vt[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1};
        vt[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 1'b1, 1'b1};
        vt[7]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 1'b1};
        vt[8]  = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0};
        vt[9]  = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0};
        vt[10] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0};
        vt[11] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
        vt[12] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};
        for (int i = 0; i < 13; i++) begin
            bus.rx_code = vt[i].code; bus.rx_parity = vt[i].par;
            bus.rx_rdy = vt[i].rdy;   bus.key_ack = vt[i].ack;
            tick();
            chk("vec_valid", bus.key_valid, vt[i].exp_valid);
            chk("vec_code",  bus.key_code,  vt[i].exp_code);
            chk("vec_ext",   bus.key_ext,   vt[i].exp_ext);
            chk("vec_rel",   bus.key_rel,   vt[i].exp_rel);
            $display("vec %0d: code=%h rdy=%b ack=%b -> valid=%b code=%h ext=%b rel=%b",
                     i, vt[i].code, vt[i].rdy, vt[i].ack,
                     bus.key_valid, bus.key_code, bus.key_ext, bus.key_rel);
        end

        // Parity error clears the pending release prefix
        send(8'hF0, 1'b1, 1'b0);
        send(8'h6B, 1'b1, 1'b0);
        chk("perr_valid", bus.key_valid, 0);
        chk("perr_cnt",   bus.perr_cnt,  1);
        wait_recover("perr_pulse", 1'b0);
        chk("perr_idle", bus.idle, 1);
        send(8'h1C, 1'b0, 1'b0);
        chk("perr_after_valid", bus.key_valid, 1);
        chk("perr_after_code",  bus.key_code,  8'h1C);
        chk("perr_after_rel",   bus.key_rel,   0);
        chk("perr_after_ext",   bus.key_ext,   0);
        bus.key_ack = 1'b1; tick();
        $display("seq parity_error: perr_cnt=%0d", bus.perr_cnt);

        // rx_error wins over a simultaneous byte; bytes during RECOVER are dropped
        bus.rx_error = 1'b1;
        send(8'h1C, 1'b0, 1'b0);
        bus.rx_error = 1'b0;
        chk("rxerr_valid", bus.key_valid, 0);
        chk("rxerr_rst",   bus.rx_reset,  1);
        wait_recover("rxerr_pulse", 1'b1);
        chk("rxerr_idle",       bus.idle,      1);
        chk("rxerr_after_valid", bus.key_valid, 0);
        $display("seq rx_error: idle=%b", bus.idle);

        // Overflow, then push with simultaneous pop while full
        for (int i = 1; i <= 9; i++) send(8'(i), par_of(8'(i)), 1'b0);
        chk("ovf_set",  bus.overflow, 1);
        chk("ovf_head", bus.key_code, 8'h01);
        send(8'h0A, par_of(8'h0A), 1'b1);
        chk("ovf_keep", bus.overflow, 1);
        exp_pop = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        foreach (exp_pop[k]) begin
            chk("ovf_pop_valid", bus.key_valid, 1);
            chk("ovf_pop_code",  bus.key_code,  exp_pop[k]);
            bus.key_ack = 1'b1; tick();
        end
        chk("ovf_empty", bus.key_valid, 0);
        bus.ovf_clr = 1'b1; tick();
        chk("ovf_clr", bus.overflow, 0);
        $display("seq overflow: drained, overflow=%b", bus.overflow);

        // Parity-error counter saturation, then asynchronous reset mid-RECOVER
        for (int i = 0; i < 256; i++) begin
            send(8'h6B, 1'b1, 1'b0);
            wait_recover("sat_pulse", 1'b0);
        end
        chk("sat_perr", bus.perr_cnt, 255);
        send(8'h1C, 1'b0, 1'b0);
        send(8'h6B, 1'b1, 1'b0);
        chk("sat_hold", bus.perr_cnt, 255);
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_rxrst", bus.rx_reset,  0);
        chk("arst_valid", bus.key_valid, 0);
        chk("arst_perr",  bus.perr_cnt,  0);
        chk("arst_code",  bus.key_code,  0);
        model_reset();
        #2 rst = 1'b0;
        $display("seq saturation+async_reset: perr_cnt=%0d rx_reset=%b", bus.perr_cnt, bus.rx_reset);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            int pick;
            logic [7:0] c;
            pick = $urandom_range(0, 9);
            if (pick < 2)      c = 8'hE0;
            else if (pick < 4) c = 8'hF0;
            else               c = 8'($urandom_range(0, 255));
            bus.rx_code   = c;
            bus.rx_parity = par_of(c) ^ ($urandom_range(0, 24) == 0);
            bus.rx_rdy    = ($urandom_range(0, 2) == 0);
            bus.rx_error  = ($urandom_range(0, 99) == 0);
            bus.rx_busy   = 1'($urandom_range(0, 1));
            bus.key_ack   = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            bus.ovf_clr   = ($urandom_range(0, 29) == 0);
            tick();
        end
        bus.rx_error = 1'b0;
        bus.rx_busy  = 1'b0;
        $display("seq random: 3000 cycles");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_scan_ctl.md
Name: ps2_scan_ctl

Overview:
- Controller that sits between the PS/2 serial receiver and the host keyboard interface.
- Consumes each received byte (code, parity, rdy, error, busy) and checks odd parity.
- Decodes the set-2 prefixes 0xE0 (extended) and 0xF0 (release), and assembles key events.
- Buffers events in a small FIFO for the host and sequences receiver recovery (reset pulse) after framing or parity errors.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of 2, minimum 2.
- AW, 3: FIFO address width, equal to log2(DEPTH).
- RST_CYCLES, 16: length of the rx_reset pulse in clk cycles, 1..255.

Ports:
- clk  in  1  main clock.
- reset  in  1  asynchronous, active-high reset.
- rx_code  in  8  received byte from receiver.
- rx_parity  in  1  received parity bit.
- rx_rdy  in  1  one-cycle pulse: byte valid.
- rx_error  in  1  receiver error flag (level).
- rx_busy  in  1  receiver mid-frame.
- rx_reset  out  1  synchronous reset to receiver.
- key_valid  out  1  FIFO not empty.
- key_code  out  8  head event scancode.
- key_ext  out  1  head event had E0 prefix.
- key_rel  out  1  head event had F0 prefix.
- key_ack  in  1  host pops head when key_valid.
- overflow  out  1  sticky: event dropped on full FIFO.
- ovf_clr  in  1  clears overflow.
- perr_cnt  out  8  saturating parity-error count.
- idle  out  1  state==IDLE and !rx_busy.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, FIFO empty, rx_reset=0, overflow=0, perr_cnt=0.
  - key_valid=0, key_code=0, key_ext=0, key_rel=0.
- Parity: a byte is good when the XOR of rx_code and rx_parity is 1 (odd parity). Parity is evaluated only in the cycle rx_rdy=1.
- State machine (one transition per rx_rdy):
  - IDLE:
    - good E0 -> EXT.
    - good F0 -> REL.
    - any other good byte -> push {ext=0, rel=0, code}, stay IDLE.
  - EXT:
    - good F0 -> EXTREL.
    - good E0 -> stay EXT.
    - other good byte -> push {1, 0, code} -> IDLE.
  - REL:
    - good E0/F0 -> stay REL (prefix ignored).
    - other good byte -> push {0, 1, code} -> IDLE.
  - EXTREL:
    - good E0/F0 -> stay EXTREL.
    - other good byte -> push {1, 1, code} -> IDLE.
  - Any state, bad parity on rx_rdy:
    - discard the byte, perr_cnt += 1 (saturates at 255), prefixes dropped -> RECOVER.
  - Any state except RECOVER, rx_error=1:
    - -> RECOVER, prefixes dropped.
    - rx_error has priority over a simultaneous rx_rdy; that byte is discarded.
  - RECOVER:
    - rx_reset=1 for exactly RST_CYCLES cycles, starting the cycle after entry; then -> IDLE.
    - rx_rdy and rx_error are ignored while in RECOVER.
- rx_reset is registered. It is 1 only in RECOVER.
- Other passthrough: E1, AA, FA and similar bytes are ordinary codes and are pushed.
- FIFO:
  - Show-ahead; key_code/key_ext/key_rel reflect the head entry while key_valid=1.
  - Latency: an event pushed on cycle N (rx_rdy at N) has key_valid=1 at N+1.
  - key_ack with key_valid=1 pops. key_ack while empty is ignored.
  - Full and no pop this cycle: push is dropped and overflow is set.
  - Full with a simultaneous pop: push is accepted and count is unchanged.
  - Empty with a simultaneous push and ack: the ack is ignored (key_valid was 0).
  - Pointers wrap modulo DEPTH. Count is AW+1 bits.
- overflow is cleared by ovf_clr. A set condition in the same cycle wins.
- Head fields when empty: hold the last value; the host must qualify them with key_valid.

Test Plan:
- Basic press: rx_rdy with 0x1C, parity 0.
  -> next cycle key_valid=1, key_code=0x1C, ext=0, rel=0.
  -> key_ack -> key_valid=0.
- Extended release: E0 (p=0), F0 (p=1), 75 (p=0), each a single rx_rdy pulse.
  -> exactly one event: code=0x75, ext=1, rel=1; no events for the prefixes.
- Parity error: F0 (p=1), then 6B with p=1 (bad).
  -> no event, perr_cnt=1, rx_reset high for 16 cycles.
  -> then 1C (p=0) gives {0, 0, 0x1C}, proving the release prefix was cleared.
- Receiver error: rx_error=1 together with rx_rdy of 0x1C.
  -> no push, RECOVER, rx_reset pulse of RST_CYCLES.
  -> rx_rdy during RECOVER is ignored; idle returns to 1 afterwards.
- Overflow: push 8 codes 0x01..0x08 without ack, then 0x09.
  -> overflow=1, FIFO holds 01..08.
  -> push 0x0A with simultaneous ack -> accepted; pop order is 02..08, 0A.
  -> ovf_clr -> overflow=0.
- Saturation and reset: 256 bad-parity bytes -> perr_cnt=255.
  -> assert reset mid-RECOVER -> rx_reset=0, FIFO empty, perr_cnt=0 immediately (async).
